// File: rtl/cim_pkg.sv
// cim_pkg: shared tile geometry, line sizing and partial-sum buffer state encoding
package cim_pkg;
  localparam int TILE_DIM = 6;
  localparam int ELEM_W   = 12;
  localparam int DATA_W   = 512;
  localparam int ADDR_W   = 8;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} psum_state_e;
endpackage

// File: rtl/psum_ram.sv
// psum_ram: 1R1W line storage, synchronous read, no reset; PSUM_FWD_EN makes same-address read/write return the new data
module psum_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = cim_pkg::DATA_W,
  parameter int ADDR_W = cim_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  assign rd_data_o = rd_data_q;
  // write port: callers guarantee wr_addr_i < DEPTH whenever wr_en_i is set
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end
  // read port: data register holds its value while no read is issued
  always_ff @(posedge clk) begin
`ifdef PSUM_FWD_EN
    if (rd_en_i) rd_data_q <= (wr_en_i && wr_addr_i == rd_addr_i) ? wr_data_i : mem_q[rd_addr_i];
`else
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
`endif
  end
endmodule

// File: rtl/psum_buffer.sv
// psum_buffer: partial-sum line buffer with PE read/write-back, bulk clear and drain streaming; macro PSUM_FWD_EN selects write-first forwarding
module psum_buffer #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = cim_pkg::DATA_W,
  parameter int ADDR_W = cim_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] memory_data_o,
  output logic [ADDR_W-1:0] memory_addr_o,
  output logic              memory_valid_o,
  input  logic [DATA_W-1:0] result_i,
  input  logic [ADDR_W-1:0] result_addr_i,
  input  logic              result_valid_i,
  input  logic              clear_i,
  input  logic              drain_req_i,
  output logic [DATA_W-1:0] drain_data_o,
  output logic [ADDR_W-1:0] drain_addr_o,
  output logic              drain_valid_o,
  input  logic              drain_ready_i,
  output logic              busy_o
);
  import cim_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  psum_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q, mem_addr_q, drain_addr_q, ram_ra, ram_wa;
  logic              done_q, mem_valid_q, mem_oor_q, drain_valid_q;
  logic              idle, drain_issue, drain_fire, ram_re, ram_we;
  logic [DATA_W-1:0] ram_wd, ram_rd;
  assign idle        = state_q == IDLE;
  assign drain_issue = state_q == DRAIN && !done_q && (!drain_valid_q || drain_ready_i);
  assign drain_fire  = drain_valid_q && drain_ready_i;
  assign ram_re      = (idle && rd_req_i) || drain_issue;
  assign ram_ra      = state_q == DRAIN ? cnt_q : rd_addr_i;
  assign ram_we      = rst_n && (state_q == CLEAR || (idle && result_valid_i && 32'(result_addr_i) < DEPTH));
  assign ram_wa      = state_q == CLEAR ? cnt_q : result_addr_i;
  assign ram_wd      = state_q == CLEAR ? '0 : result_i;
  assign memory_data_o  = (mem_valid_q && !mem_oor_q) ? ram_rd : '0;
  assign memory_addr_o  = mem_addr_q;
  assign memory_valid_o = mem_valid_q;
  assign drain_data_o   = drain_valid_q ? ram_rd : '0;
  assign drain_addr_o   = drain_addr_q;
  assign drain_valid_o  = drain_valid_q;
  assign busy_o         = state_q != IDLE;

  psum_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rd_en_i   (ram_re),
    .rd_addr_i (ram_ra),
    .rd_data_o (ram_rd),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_wa),
    .wr_data_i (ram_wd)
  );

  // PE read response: one-cycle pulse tagged with its address; out-of-range lines read as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_oor_q   <= 1'b0;
    end else begin
      mem_valid_q <= idle && rd_req_i;
      mem_addr_q  <= (idle && rd_req_i) ? rd_addr_i : mem_addr_q;
      mem_oor_q   <= (idle && rd_req_i) ? 32'(rd_addr_i) >= DEPTH : mem_oor_q;
    end
  end

  // sequencer: clear sweeps every line once, drain streams lines in order with the RAM register as the hold stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      drain_valid_q <= 1'b0;
      drain_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q         <= '0;
          done_q        <= 1'b0;
          drain_valid_q <= 1'b0;
          state_q       <= clear_i ? CLEAR : drain_req_i ? DRAIN : IDLE;
        end
        CLEAR: begin
          cnt_q   <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == LAST ? IDLE : CLEAR;
        end
        DRAIN: begin
          if (drain_issue) begin
            drain_addr_q <= cnt_q;
            done_q       <= cnt_q == LAST;
            cnt_q        <= cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
          end
          drain_valid_q <= drain_issue || (drain_valid_q && !drain_ready_i);
          if (drain_fire && drain_addr_q == LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_buffer.sv
// tb_psum_buffer: directed table, hand sequences and randomized traffic against a line-array model
module tb_psum_buffer;
  localparam int DW = 512;
  localparam int AW = 8;
  localparam int N  = 256;
`ifdef PSUM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] memory_data_o;
  logic [AW-1:0] memory_addr_o;
  logic          memory_valid_o;
  logic [DW-1:0] result_i;
  logic [AW-1:0] result_addr_i;
  logic          result_valid_i;
  logic          clear_i;
  logic          drain_req_i;
  logic [DW-1:0] drain_data_o;
  logic [AW-1:0] drain_addr_o;
  logic          drain_valid_o;
  logic          drain_ready_i;
  logic          busy_o;

  psum_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
    .memory_data_o(memory_data_o), .memory_addr_o(memory_addr_o), .memory_valid_o(memory_valid_o),
    .result_i(result_i), .result_addr_i(result_addr_i), .result_valid_i(result_valid_i),
    .clear_i(clear_i), .drain_req_i(drain_req_i),
    .drain_data_o(drain_data_o), .drain_addr_o(drain_addr_o), .drain_valid_o(drain_valid_o),
    .drain_ready_i(drain_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  logic [DW-1:0] model [N];
  vec_t tbl [6];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(input int a);
    return {16{32'(a) + 32'h5a00_1000}};
  endfunction

  task automatic op(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic rd, input logic [AW-1:0] ra);
    result_valid_i = wr;
    result_addr_i  = wa;
    result_i       = wd;
    rd_req_i       = rd;
    rd_addr_i      = ra;
    tick();
    result_valid_i = 1'b0;
    rd_req_i       = 1'b0;
  endtask

  task automatic read_chk(input string name, input int a);
    op(1'b0, '0, '0, 1'b1, AW'(a));
    chk({name, "_valid"}, DW'(memory_valid_o), DW'(1));
    chk({name, "_addr"}, DW'(memory_addr_o), DW'(a));
    chk({name, "_data"}, memory_data_o, model[a]);
  endtask

  initial begin
    int n, idx, stalled, any_v;
    logic rdy, last_seen;
    logic [DW-1:0] hold_d, exp;
    logic [AW-1:0] hold_a, wa, ra;
    logic wr, rd;
    rst_n = 1'b0; rd_req_i = 1'b0; rd_addr_i = '0; result_i = '0; result_addr_i = '0;
    result_valid_i = 1'b0; clear_i = 1'b0; drain_req_i = 1'b0; drain_ready_i = 1'b0;
    tick(); tick();
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_mvalid", DW'(memory_valid_o), DW'(0));
    chk("rst_dvalid", DW'(drain_valid_o), DW'(0));
    chk("rst_mdata", memory_data_o, '0);
    chk("rst_maddr", DW'(memory_addr_o), DW'(0));
    chk("rst_ddata", drain_data_o, '0);
    chk("rst_daddr", DW'(drain_addr_o), DW'(0));
    rst_n = 1'b1;

    // clear and drain together: clear wins, reads ignored while busy
    clear_i = 1'b1; drain_req_i = 1'b1;
    tick();
    clear_i = 1'b0; drain_req_i = 1'b0; rd_req_i = 1'b1; rd_addr_i = 8'd3;
    n = 0; any_v = 0;
    while (busy_o && n < 1000) begin
      n++;
      if (memory_valid_o) any_v = 1;
      tick();
    end
    rd_req_i = 1'b0;
    chk("clear_busy_cycles", DW'(n), DW'(N));
    chk("clear_no_mvalid", DW'(any_v), DW'(0));
    for (int i = 0; i < N; i++) model[i] = '0;
    tick(); tick();
    chk("clear_wins_busy", DW'(busy_o), DW'(0));
    chk("clear_wins_dvalid", DW'(drain_valid_o), DW'(0));
    read_chk("rd5", 5);
    tick();
    chk("rd5_pulse_end", DW'(memory_valid_o), DW'(0));

    // directed table of IDLE read/write vectors
    tbl[0] = '{1'b1, 8'd7, 512'hABC, 1'b0, 8'd0, 1'b0, '0};
    tbl[1] = '{1'b0, 8'd0, '0,       1'b1, 8'd7, 1'b1, 512'hABC};
    tbl[2] = '{1'b1, 8'd9, 512'h123, 1'b1, 8'd9, 1'b1, FWD ? 512'h123 : 512'h0};
    tbl[3] = '{1'b0, 8'd0, '0,       1'b1, 8'd9, 1'b1, 512'h123};
    tbl[4] = '{1'b1, 8'd8, 512'h55,  1'b1, 8'd7, 1'b1, 512'hABC};
    tbl[5] = '{1'b0, 8'd0, '0,       1'b1, 8'd8, 1'b1, 512'h55};
    for (int i = 0; i < 6; i++) begin
      op(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra);
      chk($sformatf("tbl%0d_valid", i), DW'(memory_valid_o), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), memory_data_o, tbl[i].ed);
        chk($sformatf("tbl%0d_addr", i), DW'(memory_addr_o), DW'(tbl[i].ra));
      end
      if (tbl[i].wr) model[tbl[i].wa] = tbl[i].wd;
    end

    // randomized traffic against the line model
    for (int c = 0; c < 400; c++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 15));
      ra = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 15));
      exp = rnd_line();
      op(wr, wa, exp, rd, ra);
      chk("rnd_valid", DW'(memory_valid_o), DW'(rd));
      if (rd) begin
        chk("rnd_addr", DW'(memory_addr_o), DW'(ra));
        chk("rnd_data", memory_data_o, (FWD && wr && wa == ra) ? exp : model[ra]);
      end
      if (wr) model[wa] = exp;
    end

    // drain with ready toggling 1,0,1,0
    drain_req_i = 1'b1;
    tick();
    drain_req_i = 1'b0;
    idx = 0; rdy = 1'b1; stalled = 0; last_seen = 1'b0;
    for (int c = 0; c < 2000 && busy_o; c++) begin
      if (stalled) begin
        chk("drain_hold_valid", DW'(drain_valid_o), DW'(1));
        chk("drain_hold_addr", DW'(drain_addr_o), DW'(hold_a));
        chk("drain_hold_data", drain_data_o, hold_d);
      end
      drain_ready_i = rdy;
      last_seen = 1'b0;
      if (drain_valid_o && rdy) begin
        chk("drain_addr", DW'(drain_addr_o), DW'(idx % N));
        chk("drain_data", drain_data_o, model[idx % N]);
        idx++;
        last_seen = idx == N;
      end
      stalled = drain_valid_o && !rdy;
      hold_a = drain_addr_o; hold_d = drain_data_o;
      rdy = !rdy;
      tick();
      if (last_seen) chk("drain_exit_busy", DW'(busy_o), DW'(0));
    end
    drain_ready_i = 1'b0;
    chk("drain_beats", DW'(idx), DW'(N));
    chk("drain_done_busy", DW'(busy_o), DW'(0));
    tick();
    chk("drain_done_dvalid", DW'(drain_valid_o), DW'(0));

    // reset aborts a clear at cycle 100
    for (int a = 0; a < N; a++) begin
      op(1'b1, AW'(a), pat(a), 1'b0, '0);
      model[a] = pat(a);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      tick();
    end
    chk("abort_reached", DW'(n), DW'(100));
    rst_n = 1'b0;
    tick();
    chk("abort_busy", DW'(busy_o), DW'(0));
    chk("abort_mvalid", DW'(memory_valid_o), DW'(0));
    rst_n = 1'b1;
    for (int a = 0; a < 100; a++) model[a] = '0;
    tick(); tick();
    chk("abort_idle", DW'(busy_o), DW'(0));
    read_chk("abort_rd0", 0);
    read_chk("abort_rd99", 99);
    read_chk("abort_rd100", 100);
    read_chk("abort_rd101", 101);
    read_chk("abort_rd200", 200);
    read_chk("abort_rd255", 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
